// File: rtl/mux_pipe_n_if.sv
// mux_pipe_n_if: handshake/data bundle between mux_pipe_n and its neighbours.
//   master : upstream/downstream side (drives flush, in_valid, sel, din, out_ready)
//   slave  : the mux stage itself (drives in_ready, out_valid, dout[, sel_err])
// Optional macro: MUX_PIPE_SELCHK_EN adds the sticky sel_err status line.
interface mux_pipe_n_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          sel;
    logic [NUM_IN*WIDTH-1:0]   din;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          dout;
`ifdef MUX_PIPE_SELCHK_EN
    logic                      sel_err;

    modport master (output flush, in_valid, sel, din, out_ready,
                    input  in_ready, out_valid, dout, sel_err);
    modport slave  (input  flush, in_valid, sel, din, out_ready,
                    output in_ready, out_valid, dout, sel_err);
`else
    modport master (output flush, in_valid, sel, din, out_ready,
                    input  in_ready, out_valid, dout);
    modport slave  (input  flush, in_valid, sel, din, out_ready,
                    output in_ready, out_valid, dout);
`endif
endinterface

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: NUM_IN-input, WIDTH-bit select mux feeding a two-entry skid
// buffer; full throughput, 1-cycle latency, strict FIFO order, flushable.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - mux_pipe_n_if.slave: flush, in_valid/in_ready, sel, din (input k at
//          din[k*WIDTH +: WIDTH]), out_valid/out_ready, dout[, sel_err]
// Optional macro: MUX_PIPE_SELCHK_EN enables sel_err, set when a beat with
// sel >= NUM_IN is accepted and held until rst or flush.
module mux_pipe_n #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic         clk,
    input  logic         rst,
    mux_pipe_n_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   beat;
    logic               rdy_q;
    logic               accept;
    logic               drain;

    // Input select; out-of-range indices fall back to input 0.
    always_comb begin
        beat = bus.din[WIDTH-1:0];
        for (int unsigned k = 1; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                beat = bus.din[k*WIDTH +: WIDTH];
            end
        end
    end

    // rdy_q stays low through reset and rises on the first clock after it,
    // so in_ready never asserts in the same cycle reset is released.
    assign bus.in_ready  = rdy_q & (state != TWO) & ~bus.flush & ~rst;
    assign bus.out_valid = (state != EMPTY);
    assign bus.dout      = main_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

`ifdef MUX_PIPE_SELCHK_EN
    logic sel_oob;
    logic err_q;

    assign sel_oob     = (32'(bus.sel) >= NUM_IN);
    assign bus.sel_err = err_q;

    // Sticky out-of-range select flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.flush) begin
            err_q <= 1'b0;
        end else if (accept && sel_oob) begin
            err_q <= 1'b1;
        end
    end
`endif

    // Skid-buffer control: main holds the head beat, skid the second one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (bus.flush) begin
                // Any concurrent drain has already completed downstream;
                // buffer contents stay but are no longer valid.
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state  <= ONE;
                            main_q <= beat;
                        end
                    end
                    ONE: begin
                        if (accept && drain) begin
                            main_q <= beat;
                        end else if (accept) begin
                            state  <= TWO;
                            skid_q <= beat;
                        end else if (drain) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (drain) begin
                            state  <= ONE;
                            main_q <= skid_q;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule
